// File: rtl/idli_pkg.sv
// Shared types for the idli serial core: predicate register names,
// compare conditions and the compare unit's FSM state.
package idli_pkg;

  // Predicate register index; P3 is hardwired to one and never written.
  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } preg_t;

  // Compare conditions evaluated by the nibble-serial compare unit.
  typedef enum logic [2:0] {
    EQ   = 3'd0,
    NE   = 3'd1,
    LT   = 3'd2,
    GE   = 3'd3,
    LTU  = 3'd4,
    GEU  = 3'd5,
    ANY  = 3'd6,
    NONE = 3'd7
  } cmp_op_t;

  // Number of nibbles making up one 16-bit operand.
  localparam int CMP_NIBBLES = 4;

  // Compare unit FSM state, also exported for observation.
  typedef enum logic {
    CMP_IDLE = 1'b0,
    CMP_RUN  = 1'b1
  } cmp_state_t;

  // Pick the predicate result for a condition from the final flags.
  function automatic logic cmp_select(input cmp_op_t op, input logic eq,
                                      input logic any, input logic lt,
                                      input logic ltu);
    logic r;
    case (op)
      EQ:      r = eq;
      NE:      r = ~eq;
      LT:      r = lt;
      GE:      r = ~lt;
      LTU:     r = ltu;
      GEU:     r = ~ltu;
      ANY:     r = any;
      default: r = ~any;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idli_cmp_m_if.sv
// Nibble stream into the compare unit and its predicate write out.
//
// Handshake: a nibble is accepted on every rising edge where i_cmp_vld is
// high; there is no back-pressure (the unit always accepts). i_cmp_start
// marks nibble 0 and only counts together with i_cmp_vld. o_cmp_wr_en is a
// single-cycle strobe qualifying o_cmp_q/o_cmp_data for the PRF.
interface idli_cmp_m_if;
  import idli_pkg::*;

  logic    i_cmp_start;
  logic    i_cmp_vld;
  logic [3:0] i_cmp_a;
  logic [3:0] i_cmp_b;
  cmp_op_t i_cmp_op;
  preg_t   i_cmp_q;
  logic    i_cmp_p_data;
  logic    o_cmp_busy;
  logic    o_cmp_wr_en;
  preg_t   o_cmp_q;
  logic    o_cmp_data;

  modport slave (
    input  i_cmp_start, i_cmp_vld, i_cmp_a, i_cmp_b, i_cmp_op, i_cmp_q,
           i_cmp_p_data,
    output o_cmp_busy, o_cmp_wr_en, o_cmp_q, o_cmp_data
  );

  modport master (
    output i_cmp_start, i_cmp_vld, i_cmp_a, i_cmp_b, i_cmp_op, i_cmp_q,
           i_cmp_p_data,
    input  o_cmp_busy, o_cmp_wr_en, o_cmp_q, o_cmp_data
  );

endinterface

// File: rtl/idli_cmp_m.sv
// Nibble-serial 16-bit compare unit. Operands arrive LSB nibble first; after
// the fourth nibble a one-cycle predicate write is produced, gated by the
// guard predicate and suppressed for the hardwired P3.
module idli_cmp_m
  import idli_pkg::*;
(
  input  logic        i_cmp_gck,
  input  logic        i_cmp_rst,
  idli_cmp_m_if.slave cmp,
  output cmp_state_t  o_cmp_state
);

  localparam logic [1:0] LAST_NIB = 2'(CMP_NIBBLES - 1);

  cmp_state_t state;
  logic [1:0] cnt;
  cmp_op_t    op;
  preg_t      q;
  logic       guard;
  logic       eq;
  logic       any;
  logic       carry;
  logic       wr_en;
  preg_t      wr_q;
  logic       wr_data;

  logic       cin;
  logic [4:0] sum;
  logic       eq_n;
  logic       any_n;
  logic       ov;
  logic       lt;
  logic       ltu;
  logic       result;

  // Per-nibble subtract step; a start nibble reseeds the chain regardless of state.
  always_comb begin
    cin    = cmp.i_cmp_start ? 1'b1 : carry;
    sum    = {1'b0, cmp.i_cmp_a} + {1'b0, ~cmp.i_cmp_b} + {4'b0000, cin};
    eq_n   = (cmp.i_cmp_a == cmp.i_cmp_b) & (cmp.i_cmp_start | eq);
    any_n  = (|(cmp.i_cmp_a & cmp.i_cmp_b)) | (~cmp.i_cmp_start & any);
    ov     = (cmp.i_cmp_a[3] != cmp.i_cmp_b[3]) & (sum[3] != cmp.i_cmp_a[3]);
    lt     = sum[3] ^ ov;
    ltu    = ~sum[4];
    result = cmp_select(op, eq_n, any_n, lt, ltu);
  end

  // FSM, accumulators and registered predicate write.
  always_ff @(posedge i_cmp_gck or posedge i_cmp_rst) begin
    if (i_cmp_rst) begin
      state   <= CMP_IDLE;
      cnt     <= 2'd0;
      op      <= EQ;
      q       <= P0;
      guard   <= 1'b0;
      eq      <= 1'b0;
      any     <= 1'b0;
      carry   <= 1'b0;
      wr_en   <= 1'b0;
      wr_q    <= P0;
      wr_data <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (cmp.i_cmp_vld) begin
        if (cmp.i_cmp_start) begin
          // New compare (or abort of a running one): latch context, seed from nibble 0.
          state <= CMP_RUN;
          cnt   <= 2'd1;
          op    <= cmp.i_cmp_op;
          q     <= cmp.i_cmp_q;
          guard <= cmp.i_cmp_p_data;
          eq    <= eq_n;
          any   <= any_n;
          carry <= sum[4];
        end else if (state == CMP_RUN) begin
          cnt   <= cnt + 2'd1;
          eq    <= eq_n;
          any   <= any_n;
          carry <= sum[4];
          if (cnt == LAST_NIB) begin
            state   <= CMP_IDLE;
            wr_en   <= guard & (q != P3);
            wr_q    <= q;
            wr_data <= result;
          end
        end
      end
    end
  end

  assign cmp.o_cmp_busy  = (state == CMP_RUN);
  assign cmp.o_cmp_wr_en = wr_en;
  assign cmp.o_cmp_q     = wr_q;
  assign cmp.o_cmp_data  = wr_data;
  assign o_cmp_state     = state;

endmodule

// File: tb/tb_idli_cmp_m.sv
// Bench for the nibble-serial compare unit: directed cases plus random
// compares, with writes checked against a queue of expected results.
module tb_idli_cmp_m;
  import idli_pkg::*;

  logic       clk;
  logic       rst;
  cmp_state_t state;
  int         cyc;
  int         total;
  int         bad;

  logic [2:0] exp_q[$];
  int         exp_cyc_q[$];

  idli_cmp_m_if cmp_if ();

  idli_cmp_m dut (
    .i_cmp_gck   (clk),
    .i_cmp_rst   (rst),
    .cmp         (cmp_if.slave),
    .o_cmp_state (state)
  );

  // Clock and cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference: whole-word compare
  function automatic logic model(input logic [15:0] a, input logic [15:0] b,
                                 input cmp_op_t op);
    case (op)
      EQ:      return a == b;
      NE:      return a != b;
      LT:      return $signed(a) < $signed(b);
      GE:      return $signed(a) >= $signed(b);
      LTU:     return a < b;
      GEU:     return a >= b;
      ANY:     return (a & b) != 16'h0;
      default: return (a & b) == 16'h0;
    endcase
  endfunction

  task automatic set_in(input logic s, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input cmp_op_t op,
                        input preg_t q, input logic g);
    cmp_if.i_cmp_start  = s;
    cmp_if.i_cmp_vld    = v;
    cmp_if.i_cmp_a      = a;
    cmp_if.i_cmp_b      = b;
    cmp_if.i_cmp_op     = op;
    cmp_if.i_cmp_q      = q;
    cmp_if.i_cmp_p_data = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 1'b0, 4'h0, 4'h0, EQ, P0, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  // Drive one full compare; returns #1 after the edge accepting nibble 3
  // (plus any trailing stall), i.e. in the cycle of the write pulse.
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                         input cmp_op_t op, input preg_t q, input logic g,
                         input int stall_at, input int nstall,
                         input bit chk_busy);
    int extra;
    extra = (stall_at >= 0 && stall_at < 3) ? nstall : 0;
    if (g && q != P3) begin
      exp_q.push_back({q, model(a, b, op)});
      exp_cyc_q.push_back(cyc + 4 + extra);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(i == 0, 1'b1, a[i*4 +: 4], b[i*4 +: 4], op, q, g);
      @(negedge clk);
      if (chk_busy) chk("busy", cmp_if.o_cmp_busy, i != 0);
      @(posedge clk); #1;
      if (i == stall_at) begin
        for (int k = 0; k < nstall; k++) begin
          set_in(1'b0, 1'b0, 4'hf, 4'hf, op, q, g);
          @(posedge clk); #1;
        end
      end
    end
    set_in(1'b0, 1'b0, 4'h0, 4'h0, EQ, P0, 1'b0);
    if (chk_busy) begin
      @(negedge clk);
      chk("busy_end", cmp_if.o_cmp_busy, 0);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && cmp_if.o_cmp_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexp_wr", cmp_if.o_cmp_wr_en, 0);
      end else begin
        logic [2:0] e;
        int         c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("wr_q", cmp_if.o_cmp_q, e[2:1]);
        chk("wr_data", cmp_if.o_cmp_data, e[0]);
        chk("wr_cyc", cyc, c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_in(1'b0, 1'b0, 4'h0, 4'h0, EQ, P0, 1'b0);
    #2;
    chk("rst_busy", cmp_if.o_cmp_busy, 0);
    chk("rst_wr_en", cmp_if.o_cmp_wr_en, 0);
    chk("rst_q", cmp_if.o_cmp_q, 0);
    chk("rst_data", cmp_if.o_cmp_data, 0);
    chk("rst_state", state, CMP_IDLE);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed / unsigned split, with busy profile
    run_cmp(16'h8000, 16'h0001, LT, P0, 1'b1, -1, 0, 1'b1);
    idle(2);
    run_cmp(16'h8000, 16'h0001, LTU, P0, 1'b1, -1, 0, 1'b1);
    idle(2);

    // Equality with a two-cycle stall after nibble 1
    run_cmp(16'h1234, 16'h1234, EQ, P1, 1'b1, 1, 2, 1'b0);
    idle(2);
    run_cmp(16'h1234, 16'h1235, NE, P2, 1'b1, 1, 2, 1'b0);
    idle(2);

    // Guard low: no write, data still computed
    run_cmp(16'h00F0, 16'h0010, ANY, P1, 1'b0, -1, 0, 1'b0);
    @(negedge clk);
    chk("guard_wr_en", cmp_if.o_cmp_wr_en, 0);
    chk("guard_data", cmp_if.o_cmp_data, 1);
    idle(2);
    // P3 destination: no write, data and q still shown
    run_cmp(16'h00F0, 16'h0010, ANY, P3, 1'b1, -1, 0, 1'b0);
    @(negedge clk);
    chk("p3_wr_en", cmp_if.o_cmp_wr_en, 0);
    chk("p3_data", cmp_if.o_cmp_data, 1);
    chk("p3_q", cmp_if.o_cmp_q, P3);
    idle(2);

    // Overflow boundary then back-to-back start in the write-pulse cycle
    run_cmp(16'h7FFF, 16'hFFFF, LT, P1, 1'b1, -1, 0, 1'b0);
    run_cmp(16'h7FFF, 16'hFFFF, GE, P2, 1'b1, -1, 0, 1'b0);
    idle(2);

    // Restart on nibble 2: only the second compare writes
    set_in(1'b1, 1'b1, 4'h0, 4'hf, GEU, P1, 1'b1);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 4'h0, 4'hf, GEU, P1, 1'b1);
    @(posedge clk); #1;
    run_cmp(16'hFFFF, 16'h0000, GEU, P2, 1'b1, -1, 0, 1'b0);
    idle(2);

    // Asynchronous reset after nibble 2 of an in-flight compare
    for (int i = 0; i < 3; i++) begin
      set_in(i == 0, 1'b1, 4'h5, 4'h5, EQ, P1, 1'b1);
      @(posedge clk); #1;
    end
    set_in(1'b0, 1'b0, 4'h5, 4'h5, EQ, P1, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", cmp_if.o_cmp_busy, 0);
    chk("arst_q", cmp_if.o_cmp_q, 0);
    chk("arst_data", cmp_if.o_cmp_data, 0);
    chk("arst_state", state, CMP_IDLE);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b1, 4'h5, 4'h5, EQ, P1, 1'b1);
    @(posedge clk); #1;
    idle(4);
    run_cmp(16'hA5A5, 16'hA5A5, EQ, P0, 1'b1, -1, 0, 1'b1);
    idle(2);

    // Random compares with random stalls, guards and destinations
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom_range(0, 65535));
      run_cmp(a, b, cmp_op_t'($urandom_range(0, 7)),
              preg_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(8);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
